// File: rtl/ahblite_interconnect_arbiter.sv
// rtl/ahblite_interconnect_arbiter.sv - per-slave round-robin AHB-Lite arbiter
// Holds grants across bursts and locked sequences; tracks the data-phase owner.
module ahblite_interconnect_arbiter #(
  parameter int MASTER    = 2,
  parameter int MID_WIDTH = (MASTER == 1) ? 1 : $clog2(MASTER)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [MASTER-1:0]    mst_HSEL_i,
  input  logic [MASTER-1:0]    mst_switch_i,
  input  logic [MASTER-1:0]    mst_HMASTLOCK_i,
  input  logic                 slv_HREADY_i,
  output logic [MASTER-1:0]    mst_grant_o,
  output logic [MID_WIDTH-1:0] grant_id_o,
  output logic [MASTER-1:0]    data_grant_o,
  output logic                 locked_o
);

  typedef enum logic [1:0] {PARK, BUSY, LOCK} state_e;

  state_e                 state_q, state_d;
  logic [MASTER-1:0]      grant_q, grant_d;
  logic [MASTER-1:0]      dgrant_q, dgrant_d;
  logic [MID_WIDTH-1:0]   gid_q, gid_d;
  logic [MID_WIDTH-1:0]   rr_q, rr_d;
  logic [MID_WIDTH-1:0]   win_idx, cand_idx;
  logic                   win_found;
  logic                   arb_en;

  // Search rr+1 .. rr (owner last); the first requesting master wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= MASTER; i++) begin
      cand_idx = MID_WIDTH'((int'(rr_q) + i) % MASTER);
      if (!win_found && mst_HSEL_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    arb_en = 1'b0;
    unique case (state_q)
      PARK:    arb_en = 1'b1;
      BUSY:    arb_en = mst_switch_i[gid_q];
      LOCK:    arb_en = mst_switch_i[gid_q] & ~mst_HMASTLOCK_i[gid_q];
      default: arb_en = 1'b0;
    endcase
    arb_en = arb_en & slv_HREADY_i;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    rr_d     = rr_q;
    dgrant_d = dgrant_q;
    if (arb_en) begin
      if (win_found) begin
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        gid_d            = win_idx;
        rr_d             = win_idx;
        state_d          = mst_HMASTLOCK_i[win_idx] ? LOCK : BUSY;
      end else begin
        state_d = PARK;
      end
    end
    // The address-phase owner only advances into the data phase on HREADY.
    if (slv_HREADY_i) begin
      dgrant_d = grant_q & mst_HSEL_i;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= PARK;
      grant_q  <= MASTER'(1);
      gid_q    <= '0;
      rr_q     <= '0;
      dgrant_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      rr_q     <= rr_d;
      dgrant_q <= dgrant_d;
    end
  end

  assign mst_grant_o  = grant_q;
  assign grant_id_o   = gid_q;
  assign data_grant_o = dgrant_q;
  assign locked_o     = (state_q == LOCK);

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(grant_q));
  a_dgrant_onehot0: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot0(dgrant_q));

endmodule

// File: tb/tb_ahblite_interconnect_arbiter.sv
// tb/tb_ahblite_interconnect_arbiter.sv - scoreboard bench for the 3-master arbiter
module tb_ahblite_interconnect_arbiter;

  logic       HCLK;
  logic       HRESETn;
  logic [2:0] mst_HSEL_i;
  logic [2:0] mst_switch_i;
  logic [2:0] mst_HMASTLOCK_i;
  logic       slv_HREADY_i;
  logic [2:0] mst_grant_o;
  logic [1:0] grant_id_o;
  logic [2:0] data_grant_o;
  logic       locked_o;

  typedef struct {
    string      tag;
    logic [2:0] grant;
    logic [1:0] id;
    logic [2:0] dg;
    logic       lk;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;

  ahblite_interconnect_arbiter #(.MASTER(3)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .mst_HSEL_i      (mst_HSEL_i),
    .mst_switch_i    (mst_switch_i),
    .mst_HMASTLOCK_i (mst_HMASTLOCK_i),
    .slv_HREADY_i    (slv_HREADY_i),
    .mst_grant_o     (mst_grant_o),
    .grant_id_o      (grant_id_o),
    .data_grant_o    (data_grant_o),
    .locked_o        (locked_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [2:0] g);
    case (g)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] eg, input logic [2:0] edg, input logic elk);
    exp_t e;
    e.tag   = tag;
    e.grant = eg;
    e.id    = oh2id(eg);
    e.dg    = edg;
    e.lk    = elk;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".grant"}, 32'(mst_grant_o), 32'(e.grant));
      check_eq({e.tag, ".id"},    32'(grant_id_o),  32'(e.id));
      check_eq({e.tag, ".dgrant"}, 32'(data_grant_o), 32'(e.dg));
      check_eq({e.tag, ".locked"}, 32'(locked_o),    32'(e.lk));
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare the registered outputs.
  task automatic step(input string tag, input logic [2:0] hsel, input logic [2:0] sw,
                      input logic [2:0] lk, input logic rdy,
                      input logic [2:0] eg, input logic [2:0] edg, input logic elk);
    mst_HSEL_i      = hsel;
    mst_switch_i    = sw;
    mst_HMASTLOCK_i = lk;
    slv_HREADY_i    = rdy;
    push_exp(tag, eg, edg, elk);
    @(posedge HCLK);
    #1;
    pop_cmp();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    HRESETn         = 1'b0;
    mst_HSEL_i      = '0;
    mst_switch_i    = '0;
    mst_HMASTLOCK_i = '0;
    slv_HREADY_i    = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    push_exp("in_reset", 3'b001, 3'b000, 1'b0);
    pop_cmp();
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 3; i++)
      step("idle", 3'b000, 3'b000, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0);

    // Rotation from PARK
    step("rot0", 3'b110, 3'b000, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0);
    step("rot1", 3'b110, 3'b010, 3'b000, 1'b1, 3'b100, 3'b010, 1'b0);
    step("rot2", 3'b110, 3'b100, 3'b000, 1'b1, 3'b010, 3'b100, 1'b0);

    // Wait states freeze grant and data owner
    for (int i = 0; i < 3; i++)
      step("wait", 3'b110, 3'b010, 3'b000, 1'b0, 3'b010, 3'b100, 1'b0);
    step("wait_rel", 3'b110, 3'b010, 3'b000, 1'b1, 3'b100, 3'b010, 1'b0);

    // Locked sequence on master 0
    step("lock_win", 3'b001, 3'b100, 3'b001, 1'b1, 3'b001, 3'b000, 1'b1);
    step("lock_hold0", 3'b111, 3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 1'b1);
    step("lock_hold1", 3'b111, 3'b000, 3'b001, 1'b1, 3'b001, 3'b001, 1'b1);
    step("lock_hold2", 3'b111, 3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 1'b1);
    step("lock_drop", 3'b110, 3'b001, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0);

    // Data-phase owner tracking
    step("dg_setup", 3'b001, 3'b010, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0);
    step("dg_move", 3'b011, 3'b001, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0);
    step("dg_next", 3'b011, 3'b000, 3'b000, 1'b1, 3'b010, 3'b010, 1'b0);
    step("dg_wait0", 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b010, 1'b0);
    step("dg_wait1", 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b010, 1'b0);
    step("park", 3'b000, 3'b010, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0);
    step("parked", 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0);

    // Lock on master 2, then asynchronous reset mid-lock
    step("lock2", 3'b100, 3'b000, 3'b100, 1'b1, 3'b100, 3'b000, 1'b1);
    step("lock2_hold", 3'b100, 3'b000, 3'b100, 1'b1, 3'b100, 3'b100, 1'b1);
    #2;
    HRESETn         = 1'b0;
    mst_HSEL_i      = '0;
    mst_switch_i    = '0;
    mst_HMASTLOCK_i = '0;
    #1;
    push_exp("async_rst", 3'b001, 3'b000, 1'b0);
    pop_cmp();
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Rotation restarts with master 1 first
    step("rr0", 3'b111, 3'b000, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0);
    step("rr1", 3'b111, 3'b010, 3'b000, 1'b1, 3'b100, 3'b010, 1'b0);
    step("rr2", 3'b111, 3'b100, 3'b000, 1'b1, 3'b001, 3'b100, 1'b0);
    step("rr3", 3'b111, 3'b001, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0);
    step("keep", 3'b010, 3'b010, 3'b000, 1'b1, 3'b010, 3'b010, 1'b0);
    step("keep_rr", 3'b111, 3'b010, 3'b000, 1'b1, 3'b100, 3'b010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
